ahb_sram_slave: RTL and testbench
=================================

AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 SHALL have parameter MEM_DEPTH, default 256; number of 32-bit words, power of two.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2; wait states per data phase (used only under REQ-021).
REQ-003 SHALL have ports HCLK input 1, the single clock; all logic on posedge.
REQ-004 SHALL have ports HRESETn input 1, reset, synchronous, active-low.
REQ-005 SHALL have ports HSEL input 1, slave select.
REQ-006 SHALL have ports HADDR input 32, HTRANS input 2, HWRITE input 1, HSIZE input 3, HWDATA input 32, the AHB-Lite master signals.
REQ-007 SHALL have ports HREADY input 1, bus-wide ready; HREADYOUT output 1; HRDATA output 32; HRESP output 1 (0 = OKAY, 1 = ERROR).

Function
REQ-008 An address phase SHALL be accepted when HSEL=1, HREADY=1 and HTRANS is NONSEQ (2'b10) or SEQ (2'b11); HADDR, HWRITE and HSIZE are registered then.
REQ-009 IDLE, BUSY or unselected address phases SHALL give a zero-wait OKAY data phase with no memory access.
REQ-010 FSM states SHALL be IDLE, WAIT, ERR1 and ERR2.
- IDLE: HREADYOUT=1, HRESP=0.
- WAIT: HREADYOUT=0, HRESP=0.
- ERR1: HREADYOUT=0, HRESP=1.
- ERR2: HREADYOUT=1, HRESP=1.
REQ-011 The error check SHALL flag an accepted transfer when any of these holds:
- word index HADDR[31:2] >= MEM_DEPTH;
- HSIZE > 3'b010;
- halfword with HADDR[0]=1;
- word with HADDR[1:0] != 0.
REQ-012 A flagged transfer SHALL go IDLE->ERR1->ERR2->IDLE, a two-cycle ERROR response, with no memory write.
REQ-013 A legal transfer SHALL complete in the first data-phase cycle (zero wait) when waits are disabled.
REQ-014 Writes SHALL sample HWDATA in the data-phase cycle where HREADYOUT=1.
- Byte lanes are selected little-endian by HSIZE and the registered HADDR[1:0].
- Unselected byte lanes are unchanged.
REQ-015 Reads SHALL present the full addressed 32-bit word on HRDATA in the cycle where HREADYOUT=1 with HRESP=0.
REQ-016 A read whose address phase coincides with the completing data phase of a write to the same word SHALL return the merged new data (forwarding).
REQ-017 HRDATA SHALL hold its last value when not completing a read.
REQ-018 An address phase presented while HREADY=0 SHALL be ignored.
- A transfer accepted in ERR2 or in the final OKAY cycle SHALL start normally the next cycle (back-to-back pipelining).

Reset
REQ-019 With HRESETn=0 at a clock edge, the block SHALL enter IDLE with HREADYOUT=1, HRESP=0 and HRDATA=0.
- Any pending write is discarded.
- The wait counter is cleared.
- Memory contents are not reset.
REQ-020 A reset asserted during WAIT, ERR1 or ERR2 SHALL abort the transfer with no memory update.

Configuration
REQ-021 Macro AHB_SRAM_SLAVE_WAIT_EN SHALL control wait-state insertion.
- Defined: each legal data phase enters WAIT for WAIT_CYCLES cycles (HREADYOUT=0), then completes with HREADYOUT=1. WAIT_CYCLES=0 behaves as undefined.
- Undefined: the WAIT state and counter are absent and legal transfers are zero-wait.
- Error responses are identical in both builds.

Structure
REQ-022 Package ahb_sram_slave_pkg SHALL hold:
- HTRANS encodings IDLE, BUSY, NONSEQ, SEQ;
- HSIZE encodings BYTE, HALF, WORD;
- HRESP encodings OKAY, ERROR;
- the FSM state enum.
REQ-023 Sub-module ahb_sram_mem SHALL hold the storage.
- One read port and one byte-enabled write port, MEM_DEPTH x 32.
- Forwarding and control stay in the top level.

Verification
REQ-024 Word write 0x0000_0010 <- 0xDEADBEEF, then word read 0x10 -> HRDATA=0xDEADBEEF, HRESP=0, zero wait (macro off).
REQ-025 Byte write 0x13 <- 0xAB000000 over prior 0xDEADBEEF, then read 0x10 -> 0xABADBEEF.
REQ-026 Word write 0x400 with MEM_DEPTH=256 -> HREADYOUT 0 then 1 with HRESP=1 for both cycles; a follow-up read of 0x0 is unaffected.
REQ-027 Halfword at 0x21 or HSIZE=3'b011 -> two-cycle ERROR, no write.
REQ-028 Back-to-back write 0x20 <- 0x12345678 then read 0x20 in the next address phase -> HRDATA=0x12345678 (forwarding).
REQ-029 Macro on, WAIT_CYCLES=2: read of 0x10 -> HREADYOUT low 2 cycles, then data; HRESETn=0 during WAIT of a write to 0x30 -> IDLE, and a later read of 0x30 returns the old contents.

Source files
------------

// File: rtl/ahb_sram_slave_pkg.sv
// ahb_sram_slave_pkg: AHB-Lite encodings, FSM states and byte-lane helpers for the SRAM slave.
package ahb_sram_slave_pkg;

    typedef enum logic [1:0] {
        HTRANS_IDLE   = 2'b00,
        HTRANS_BUSY   = 2'b01,
        HTRANS_NONSEQ = 2'b10,
        HTRANS_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [2:0] {
        HSIZE_BYTE = 3'b000,
        HSIZE_HALF = 3'b001,
        HSIZE_WORD = 3'b010
    } hsize_e;

    typedef enum logic {
        HRESP_OKAY  = 1'b0,
        HRESP_ERROR = 1'b1
    } hresp_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } state_e;

    // Little-endian lane mask for an already-legal (aligned) transfer.
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] lane);
        return size == 2'd2 ? 4'hf : size == 2'd1 ? (lane[1] ? 4'hc : 4'h3) : 4'b0001 << lane;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] m;
        m = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (new_w & m) | (old_w & ~m);
    endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// ahb_sram_mem: MEM_DEPTH x 32 storage, one asynchronous read port and one byte-enabled write port.
module ahb_sram_mem #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_we,
    input  logic [3:0]    i_be,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        for (int b = 0; b < 4; b++)
            if (i_we && i_be[b]) r_mem[i_waddr][8*b +: 8] <= i_wdata[8*b +: 8];
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite SRAM slave with two-cycle ERROR responses and write-to-read forwarding.
// Define AHB_SRAM_SLAVE_WAIT_EN to insert WAIT_CYCLES wait states in every legal data phase.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int unsigned MEM_DEPTH   = 256,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [31:0] HWDATA,
    input  logic        HREADY,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        HRESP
);

    localparam int unsigned AW = $clog2(MEM_DEPTH);

    state_e        r_state;
    logic          r_hreadyout;
    logic          r_hresp;
    logic          r_pend;
    logic          r_write;
    logic [AW-1:0] r_idx;
    logic [1:0]    r_lane;
    logic [1:0]    r_size;
    logic [31:0]   r_hrdata;
    logic          w_take;
    logic          w_err;
    logic          w_we;
    logic [3:0]    w_be;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_raddr;
    logic [31:0]   w_rdata;
    logic [31:0]   w_fwd;

`ifdef AHB_SRAM_SLAVE_WAIT_EN
    localparam int unsigned CW = WAIT_CYCLES > 1 ? $clog2(WAIT_CYCLES) : 1;
    logic [CW-1:0] r_cnt;
    assign w_raddr = r_state == ST_WAIT ? r_idx : w_idx;
`else
    assign w_raddr = w_idx;
`endif

    // Only IDLE/ERR2 end a data phase, so a new address phase is taken only while we are ready.
    assign w_take = HSEL && HREADY && r_hreadyout && (HTRANS == HTRANS_NONSEQ || HTRANS == HTRANS_SEQ);
    assign w_err  = HADDR[31:2] >= 30'(MEM_DEPTH) || HSIZE > HSIZE_WORD ||
                    (HSIZE == HSIZE_HALF && HADDR[0]) || (HSIZE == HSIZE_WORD && HADDR[1:0] != 2'b00);
    assign w_idx  = HADDR[AW+1:2];
    assign w_be   = byte_en(r_size, r_lane);
    assign w_we   = r_pend && r_hreadyout && r_write && HRESETn;
    assign w_fwd  = w_we && r_idx == w_raddr ? lane_merge(w_rdata, HWDATA, w_be) : w_rdata;

    assign HREADYOUT = r_hreadyout;
    assign HRESP     = r_hresp;
    assign HRDATA    = r_hrdata;

    ahb_sram_mem #(.DEPTH(MEM_DEPTH), .AW(AW)) u_mem (
        .i_clk   (HCLK),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_waddr (r_idx),
        .i_wdata (HWDATA),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            r_state     <= ST_IDLE;
            r_hreadyout <= 1'b1;
            r_hresp     <= HRESP_OKAY;
            r_pend      <= 1'b0;
            r_hrdata    <= '0;
`ifdef AHB_SRAM_SLAVE_WAIT_EN
            r_cnt       <= '0;
`endif
        end else begin
            if (w_take) begin
                r_idx   <= w_idx;
                r_lane  <= HADDR[1:0];
                r_size  <= HSIZE[1:0];
                r_write <= HWRITE;
            end
            case (r_state)
`ifdef AHB_SRAM_SLAVE_WAIT_EN
                ST_WAIT: begin
                    if (r_cnt == '0) begin
                        r_state     <= ST_IDLE;
                        r_hreadyout <= 1'b1;
                        if (!r_write) r_hrdata <= w_fwd;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
`endif
                ST_ERR1: begin
                    r_state     <= ST_ERR2;
                    r_hreadyout <= 1'b1;
                    r_hresp     <= HRESP_ERROR;
                end
                default: begin
                    r_pend <= w_take && !w_err;
                    if (w_take && w_err) begin
                        r_state     <= ST_ERR1;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= HRESP_ERROR;
                    end
`ifdef AHB_SRAM_SLAVE_WAIT_EN
                    else if (w_take && WAIT_CYCLES > 0) begin
                        r_state     <= ST_WAIT;
                        r_hreadyout <= 1'b0;
                        r_hresp     <= HRESP_OKAY;
                        r_cnt       <= CW'(WAIT_CYCLES - 1);
                    end
`endif
                    else begin
                        r_state     <= ST_IDLE;
                        r_hreadyout <= 1'b1;
                        r_hresp     <= HRESP_OKAY;
                        if (w_take && !HWRITE) r_hrdata <= w_fwd;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// tb_ahb_sram_slave: pipelined AHB-Lite master driving directed and random transfers against a word-array model.
module tb_ahb_sram_slave;

    localparam int DEPTH = 256;
    localparam int WAITS = 2;
`ifdef AHB_SRAM_SLAVE_WAIT_EN
    localparam int EXP_WAIT = WAITS;
`else
    localparam int EXP_WAIT = 0;
`endif

    typedef struct packed {
        bit          sel;
        logic [1:0]  trans;
        bit          wr;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } op_t;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic [2:0]  HSIZE = 3'b000;
    logic [31:0] HWDATA = '0;
    logic        HREADY;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        HRESP;
    logic        block = 1'b0;

    logic [31:0] mem_m [DEPTH];
    logic [31:0] last_rdata = '0;
    op_t         prev = '0;
    int          checks = 0;
    int          errors = 0;

    assign HREADY = HREADYOUT && !block;

    always #5 HCLK = ~HCLK;

    ahb_sram_slave #(.MEM_DEPTH(DEPTH), .WAIT_CYCLES(WAITS)) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .HSEL      (HSEL),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HWRITE    (HWRITE),
        .HSIZE     (HSIZE),
        .HWDATA    (HWDATA),
        .HREADY    (HREADY),
        .HREADYOUT (HREADYOUT),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP)
    );

    function automatic op_t mk(input bit sel, input logic [1:0] tr, input bit wr, input logic [31:0] a,
                               input logic [2:0] sz, input logic [31:0] d);
        op_t o;
        o.sel = sel; o.trans = tr; o.wr = wr; o.addr = a; o.size = sz; o.wdata = d;
        return o;
    endfunction

    function automatic bit is_err(input op_t o);
        return (o.addr >> 2) >= DEPTH || o.size > 3'd2 || (o.size == 3'd1 && o.addr[0]) ||
               (o.size == 3'd2 && o.addr[1:0] != 2'b00);
    endfunction

    // Overwrite the 1/2/4 bytes covered by the transfer, lanes counted from the aligned base.
    function automatic logic [31:0] merge(input logic [31:0] old_w, input op_t o);
        int nb = 1 << o.size;
        int base = int'(o.addr[1:0]) & ~(nb - 1);
        logic [31:0] w = old_w;
        for (int k = 0; k < nb; k++) w[8*(base+k) +: 8] = o.wdata[8*(base+k) +: 8];
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Present op's address phase while finishing prev's data phase, then score prev.
    task automatic step(input op_t op);
        int waits = 0;
        int cyc = 0;
        bit rdy = 1'b0;
        bit resp_bad = 1'b0;
        logic [31:0] rd = '0;
        bit act = prev.sel && prev.trans[1];
        bit er = act && is_err(prev);
        int idx = int'(prev.addr >> 2);
        HSEL = op.sel; HTRANS = op.trans; HWRITE = op.wr; HADDR = op.addr; HSIZE = op.size;
        HWDATA = prev.wdata;
        while (!rdy && cyc < 20) begin
            @(negedge HCLK);
            rdy = HREADYOUT;
            rd = HRDATA;
            if (HRESP !== er) resp_bad = 1'b1;
            if (!rdy) waits++;
            cyc++;
            @(posedge HCLK); #1;
        end
        chk("timeout", 32'(rdy), 32'd1);
        chk("waits", 32'(waits), act ? (er ? 32'd1 : 32'(EXP_WAIT)) : 32'd0);
        chk("hresp", 32'(resp_bad), 32'd0);
        if (act && !er && !prev.wr) begin
            chk("rdata", rd, mem_m[idx]);
            last_rdata = mem_m[idx];
        end else begin
            chk("hold", rd, last_rdata);
        end
        if (act && !er && prev.wr) mem_m[idx] = merge(mem_m[idx], prev);
        prev = op;
    endtask

    op_t idle_op;
    op_t rop;

    initial begin
        idle_op = mk(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
        repeat (3) @(posedge HCLK);
        #1 HRESETn = 1'b1;
        @(negedge HCLK);
        chk("rst_rdy", 32'(HREADYOUT), 32'd1);
        chk("rst_resp", 32'(HRESP), 32'd0);
        chk("rst_rdata", HRDATA, 32'h0);
        @(posedge HCLK); #1;

        for (int i = 0; i < DEPTH; i++) step(mk(1'b1, 2'b10, 1'b1, 32'(i * 4), 3'd2, $urandom));

        step(mk(1'b1, 2'b10, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF));
        step(mk(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'h0));
        step(mk(1'b1, 2'b10, 1'b1, 32'h13, 3'd0, 32'hAB000000));
        step(mk(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'h0));
        step(idle_op);
        step(mk(1'b1, 2'b10, 1'b1, 32'h400, 3'd2, 32'hFFFFFFFF));
        step(mk(1'b1, 2'b10, 1'b0, 32'h0, 3'd2, 32'h0));
        step(mk(1'b1, 2'b10, 1'b1, 32'h21, 3'd1, 32'h5A5A5A5A));
        step(mk(1'b1, 2'b11, 1'b1, 32'h20, 3'd3, 32'hA5A5A5A5));
        step(mk(1'b1, 2'b10, 1'b0, 32'h20, 3'd2, 32'h0));
        step(mk(1'b1, 2'b10, 1'b1, 32'h20, 3'd2, 32'h12345678));
        step(mk(1'b1, 2'b11, 1'b0, 32'h20, 3'd2, 32'h0));
        step(mk(1'b1, 2'b01, 1'b1, 32'h24, 3'd2, 32'h11111111));
        step(mk(1'b0, 2'b10, 1'b1, 32'h24, 3'd2, 32'h22222222));
        step(mk(1'b1, 2'b10, 1'b1, 32'h22, 3'd1, 32'hBEEF0000));
        step(mk(1'b1, 2'b10, 1'b0, 32'h24, 3'd2, 32'h0));
        step(mk(1'b1, 2'b10, 1'b0, 32'h20, 3'd2, 32'h0));
        step(idle_op);

        // Reset lands in the first data-phase cycle of a write to 0x30: no update may survive.
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h30; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'hBAD0BAD0; HRESETn = 1'b0;
        @(posedge HCLK); #1;
        HRESETn = 1'b1;
        @(negedge HCLK);
        chk("abort_rdy", 32'(HREADYOUT), 32'd1);
        chk("abort_resp", 32'(HRESP), 32'd0);
        chk("abort_rdata", HRDATA, 32'h0);
        @(posedge HCLK); #1;
        last_rdata = '0;
        prev = idle_op;
        step(mk(1'b1, 2'b10, 1'b0, 32'h30, 3'd2, 32'h0));
        step(idle_op);

        // An address phase with HREADY low must be ignored.
        block = 1'b1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'h40; HSIZE = 3'd2;
        @(posedge HCLK); #1;
        block = 1'b0;
        HSEL = 1'b0; HTRANS = 2'b00; HWDATA = 32'h0BADF00D;
        @(negedge HCLK);
        chk("ign_rdy", 32'(HREADYOUT), 32'd1);
        chk("ign_resp", 32'(HRESP), 32'd0);
        @(posedge HCLK); #1;
        step(mk(1'b1, 2'b10, 1'b0, 32'h40, 3'd2, 32'h0));
        step(idle_op);

        for (int i = 0; i < 300; i++) begin
            int r = $urandom_range(0, 99);
            rop.sel = r < 92;
            rop.trans = r < 12 ? 2'($urandom_range(0, 3)) : {1'b1, 1'($urandom_range(0, 1))};
            rop.wr = 1'($urandom_range(0, 1));
            rop.size = $urandom_range(0, 11) == 0 ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
            rop.addr = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            if ($urandom_range(0, 19) == 0) rop.addr = rop.addr + 32'h400;
            if (rop.size <= 3'd2 && $urandom_range(0, 9) < 8)
                rop.addr = rop.addr & ~((32'd1 << rop.size) - 32'd1);
            rop.wdata = $urandom;
            step(rop);
        end
        step(idle_op);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
